ef_smsdac_mse_ctrl: RTL and testbench
=====================================

EF_SMSDAC_MSE_CTRL -- requirements
Module: ef_smsdac_mse_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: DAC code width; midscale MID = 2^(N-1).
REQ-002 SHALL have parameter DIV_W, default 8: width of the sample-rate divider.
REQ-003 SHALL have parameter NR, default 7: number of random bits for the switching-block r inputs (NR <= 16).
REQ-004 SHALL have port clk, input, 1: clock, all logic rising-edge.
REQ-005 SHALL have port rst_b, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1: converter enable.
REQ-007 SHALL have port div, input, DIV_W: sample period minus one, in clk cycles.
REQ-008 SHALL have port mute, input, 1: soft-mute request.
REQ-009 SHALL have port s_valid, input, 1: input code valid.
REQ-010 SHALL have port s_ready, output, 1: input code accepted when s_valid & s_ready.
REQ-011 SHALL have port s_data, input, N: input code.
REQ-012 SHALL have port x_out, output, N: code to the switching-block tree.
REQ-013 SHALL have port r_out, output, NR: random bits to the switching blocks.
REQ-014 SHALL have port strobe, output, 1: one-cycle pulse when x_out/r_out take a new sample.
REQ-015 SHALL have port underrun, output, 1: one-cycle pulse, sample slot with no data.
REQ-016 SHALL have port state, output, 2: IDLE=0, RUN=1, RAMP=2, MUTED=3.

Function
REQ-017 Divider: cnt (DIV_W bits) SHALL increment every cycle outside IDLE; internal tick SHALL fire when cnt >= div, clearing cnt, giving a period of div+1 cycles; the comparison is >= so lowering div mid-count takes effect on the next cycle.
REQ-018 Hold buffer: one entry; s_ready SHALL be (~hold_v | tick) outside IDLE and 0 in IDLE; a write and a tick-consume in the same cycle SHALL leave the new data held.
REQ-019 x_out, r_out, strobe and underrun SHALL be registered and update on the clock edge at which tick is high; strobe is high exactly in the cycle in which new values first appear.
REQ-020 IDLE: en=1 SHALL go to RUN with cnt=0; first tick occurs div+1 cycles after entry.
REQ-021 en=0 in any state SHALL go to IDLE next cycle: x_out=MID, cnt=0, hold_v=0, r_out held; LFSR state retained.
REQ-022 RUN, tick, hold_v=1: x_out SHALL load the held code and the hold buffer empties.
REQ-023 RUN, tick, hold_v=0: x_out SHALL repeat its previous value and underrun SHALL pulse with strobe.
REQ-024 RUN, tick, mute=1: SHALL enter RAMP and take the first ramp step on that tick (no data loaded).
REQ-025 RAMP, each tick: x_out SHALL step by 1 toward MID; reaching MID (or already at MID) SHALL enter MUTED.
REQ-026 RAMP/MUTED: held data SHALL be consumed and discarded on each tick; underrun SHALL not assert.
REQ-027 RAMP/MUTED with mute=0 at a tick: SHALL return to RUN and apply REQ-022/REQ-023 on that same tick.
REQ-028 Random source: 16-bit Galois LFSR, right-shift, tap mask 16'hB400, seed 16'hACE1; SHALL advance once per tick in all non-IDLE states; r_out SHALL take the low NR bits of the advanced value.

Reset
REQ-029 On rst_b=0: state=IDLE, x_out=MID, r_out=0, strobe=0, underrun=0, cnt=0, hold_v=0, LFSR=16'hACE1.
REQ-030 Reset asserted mid-operation SHALL abandon any ramp or held data immediately, with no further strobe.

Configuration
REQ-031 Macro EF_SMSDAC_LFSR_EN defined: LFSR per REQ-028 drives r_out.
REQ-032 Macro EF_SMSDAC_LFSR_EN undefined: no LFSR; r_out SHALL be constant 0 (deterministic shaping), all other behaviour unchanged.

Verification (N=4, DIV_W=8, NR=7, macro defined unless stated)
REQ-033 Reset released, en=0 -> x_out=8, r_out=0, strobe=0, s_ready=0, state=0.
REQ-034 div=3, en=1 at cycle 0 -> strobe at cycles 4, 8, 12; first r_out=7'h70 (LFSR 16'hE270).
REQ-035 Push 5 then 12 back-to-back -> s_ready=0 on second push until the tick; x_out=5 then 12 on successive strobes.
REQ-036 No push after x_out=12 -> next strobe x_out=12 and underrun=1 for one cycle.
REQ-037 mute=1 with x_out=12 -> x_out 11, 10, 9, 8 on successive strobes, state=3; mute=0 with 3 held -> next strobe x_out=3, state=1.
REQ-038 Macro undefined, same run as REQ-034 -> r_out=0 on every strobe.

Source files
------------

// File: rtl/ef_smsdac_mse_ctrl_if.sv
// Input-code handshake between the sample source and ef_smsdac_mse_ctrl.
//   s_valid : source has a code on s_data
//   s_ready : controller accepts the code when s_valid & s_ready
//   s_data  : N-bit DAC code
// master modport: the source side; slave modport: the controller side.
interface ef_smsdac_mse_ctrl_if #(
  parameter int unsigned N = 4
) ();
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ef_smsdac_mse_ctrl.sv
// Sample-rate controller for a switching-block (mismatch-shaping) segmented DAC.
// Paces input codes at clk/(div+1), holds one code in a single-entry buffer, soft-mutes by
// ramping the output code one LSB per sample toward midscale, and supplies random bits to
// the switching blocks.
//
// Ports:
//   clk, rst_b : clock (rising edge) and asynchronous active-low reset
//   en         : converter enable; dropping it returns to IDLE on the next cycle
//   div        : sample period minus one, in clk cycles
//   mute       : soft-mute request
//   s          : input-code handshake (slave modport of ef_smsdac_mse_ctrl_if)
//   x_out      : code to the switching-block tree
//   r_out      : random bits to the switching blocks
//   strobe     : one-cycle pulse in the cycle x_out/r_out first show a new sample
//   underrun   : one-cycle pulse when a RUN sample slot found no held code
//   state      : IDLE=0, RUN=1, RAMP=2, MUTED=3
//
// Build option: define EF_SMSDAC_LFSR_EN to drive r_out from a 16-bit Galois LFSR;
// without it r_out is constant zero (deterministic shaping).
module ef_smsdac_mse_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned NR    = 7
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 en,
  input  logic [DIV_W-1:0]     div,
  input  logic                 mute,
  ef_smsdac_mse_ctrl_if.slave  s,
  output logic [N-1:0]         x_out,
  output logic [NR-1:0]        r_out,
  output logic                 strobe,
  output logic                 underrun,
  output logic [1:0]           state
);

  localparam logic [N-1:0]     Mid    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]     XOne   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] CntOne = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StRamp  = 2'd2,
    StMuted = 2'd3
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic             hold_v_q;
  logic [N-1:0]     hold_q;
  logic [N-1:0]     x_q;
  logic             strobe_q;
  logic             underrun_q;

  logic             tick;
  logic             ready;
  logic             wr;
  logic [N-1:0]     x_step_d;

  // >= rather than == so a lowered div takes effect immediately instead of wrapping.
  assign tick  = (state_q != StIdle) && (cnt_q >= div);
  assign ready = (state_q != StIdle) && (!hold_v_q || tick);
  assign wr    = s.s_valid && ready;

  // One LSB toward midscale; stays put when already there.
  always_comb begin
    x_step_d = x_q;
    if (x_q > Mid) begin
      x_step_d = x_q - XOne;
    end else if (x_q < Mid) begin
      x_step_d = x_q + XOne;
    end
  end

`ifdef EF_SMSDAC_LFSR_EN
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [NR-1:0] r_q;

  // Galois, right-shifting: feed the dropped bit back through the tap mask.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lfsr_q <= 16'hACE1;
      r_q    <= '0;
    end else if (en && tick) begin
      lfsr_q <= lfsr_d;
      r_q    <= lfsr_d[NR-1:0];
    end
  end

  assign r_out = r_q;
`else
  assign r_out = '0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      x_q        <= Mid;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!en) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hold_v_q   <= 1'b0;
      x_q        <= Mid;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      strobe_q   <= tick;
      underrun_q <= 1'b0;
      if (state_q == StIdle) begin
        state_q <= StRun;
        cnt_q   <= '0;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CntOne;
        // A write landing on a tick wins: the old code is consumed, the new one is kept.
        if (wr) begin
          hold_v_q <= 1'b1;
          hold_q   <= s.s_data;
        end else if (tick) begin
          hold_v_q <= 1'b0;
        end
        if (tick) begin
          if (mute) begin
            // Held code (if any) is discarded while ramping or muted.
            x_q     <= x_step_d;
            state_q <= (x_step_d == Mid) ? StMuted : StRamp;
          end else begin
            state_q <= StRun;
            if (hold_v_q) begin
              x_q <= hold_q;
            end else begin
              underrun_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign s.s_ready = ready;
  assign x_out     = x_q;
  assign strobe    = strobe_q;
  assign underrun  = underrun_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ef_smsdac_mse_ctrl.sv
// Bench for ef_smsdac_mse_ctrl (N=4, DIV_W=8, NR=7): directed scenario with literal
// expectations, then randomized stimulus checked every cycle against a behavioural model.
module tb_ef_smsdac_mse_ctrl;

  localparam int MID    = 8;
  localparam int NRMASK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       en;
  logic [7:0] div;
  logic       mute;
  logic [3:0] x_out;
  logic [6:0] r_out;
  logic       strobe;
  logic       underrun;
  logic [1:0] state;

  ef_smsdac_mse_ctrl_if #(.N(4)) sif ();

  ef_smsdac_mse_ctrl #(.N(4), .DIV_W(8), .NR(7)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .en       (en),
    .div      (div),
    .mute     (mute),
    .s        (sif),
    .x_out    (x_out),
    .r_out    (r_out),
    .strobe   (strobe),
    .underrun (underrun),
    .state    (state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  bit chk_on  = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state, m_cnt, m_x, m_r, m_hold;
  bit          m_hold_v, m_strobe, m_under;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_x = MID; m_r = 0; m_hold = 0;
    m_hold_v = 0; m_strobe = 0; m_under = 0; m_lfsr = 16'hACE1;
  endtask

  function automatic bit model_ready();
    return (m_state != 0) && (!m_hold_v || m_cnt >= int'(div));
  endfunction

  task automatic model_step();
    bit sample, accept;
    sample   = (m_state != 0) && (m_cnt >= int'(div));
    accept   = sif.s_valid && model_ready();
    m_strobe = 0;
    m_under  = 0;
    if (!en) begin
      m_state = 0; m_x = MID; m_cnt = 0; m_hold_v = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_cnt = 0;
    end else begin
      if (sample) begin
        m_cnt    = 0;
        m_strobe = 1;
        m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
`ifdef EF_SMSDAC_LFSR_EN
        m_r = int'(m_lfsr) & NRMASK;
`else
        m_r = 0;
`endif
        if (mute) begin
          if (m_x > MID) m_x = m_x - 1;
          else if (m_x < MID) m_x = m_x + 1;
          m_state = (m_x == MID) ? 3 : 2;
        end else begin
          m_state = 1;
          if (m_hold_v) m_x = m_hold;
          else m_under = 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (accept) begin
        m_hold_v = 1; m_hold = int'(sif.s_data);
      end else if (sample) begin
        m_hold_v = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_b);
      if (!rst_b) model_reset();
      else model_step();
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("x_out",    x_out,        m_x);
      check("r_out",    r_out,        m_r);
      check("strobe",   strobe,       m_strobe);
      check("underrun", underrun,     m_under);
      check("state",    state,        m_state);
      check("s_ready",  sif.s_ready,  model_ready());
    end
  end

  // Record of every strobe, for the directed literal checks.
  typedef struct {int x; int r; int un; int st; int cy;} srec_t;
  srec_t sq[$];

  always @(posedge clk) begin
    #1;
    if (strobe === 1'b1) sq.push_back('{int'(x_out), int'(r_out), int'(underrun),
                                       int'(state), cyc});
  end

  task automatic wait_q(input int n);
    int k = 0;
    while (sq.size() < n && k < 500) begin
      @(posedge clk); #3;
      k++;
    end
    if (sq.size() < n) begin
      vectors++;
      errs++;
      $display("FAIL strobe_timeout: got %0d strobes, expected %0d", sq.size(), n);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic push(input logic [3:0] d, output bit first_ready);
    int k = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    #1;
    first_ready = sif.s_ready;
    while (!sif.s_ready && k < 500) begin
      @(posedge clk); #3;
      k++;
    end
    if (!sif.s_ready) check("push_timeout", 0, 1);
    @(posedge clk); #2;
    sif.s_valid = 1'b0;
  endtask

  function automatic srec_t ent(input int i);
    srec_t z = '{0, 0, 0, 0, 0};
    if (i < sq.size()) return sq[i];
    return z;
  endfunction

  initial begin
    bit rdy;
    int c0;
    rst_b = 1'b0; en = 1'b0; div = 8'd3; mute = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = '0;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    #2 rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_x_out",   x_out,       8);
    check("rst_r_out",   r_out,       0);
    check("rst_strobe",  strobe,      0);
    check("rst_s_ready", sif.s_ready, 0);
    check("rst_state",   state,       0);

    // Enable with div=3: strobes 4, 8, 12 cycles after the entry edge.
    @(posedge clk); #2;
    en = 1'b1;
    c0 = cyc + 1;
    wait_q(3);
    check("strobe1_cycle", ent(0).cy - c0, 4);
    check("strobe2_cycle", ent(1).cy - c0, 8);
    check("strobe3_cycle", ent(2).cy - c0, 12);
`ifdef EF_SMSDAC_LFSR_EN
    check("first_r_out", ent(0).r, 7'h70);
`else
    check("first_r_out", ent(0).r, 0);
`endif

    // Back-to-back pushes of 5 and 12.
    @(posedge clk); #2;
    push(4'd5, rdy);
    push(4'd12, rdy);
    check("second_push_ready", rdy, 0);
    wait_q(6);
    check("x_after_push5",  ent(3).x, 5);
    check("x_after_push12", ent(4).x, 12);
    check("underrun_x",     ent(5).x, 12);
    check("underrun_flag",  ent(5).un, 1);

    // Soft mute ramp 12 -> 8, then unmute with 3 held.
    mute = 1'b1;
    wait_q(10);
    check("ramp_x1", ent(6).x, 11);
    check("ramp_x2", ent(7).x, 10);
    check("ramp_x3", ent(8).x, 9);
    check("ramp_x4", ent(9).x, 8);
    check("muted_state", ent(9).st, 3);
    @(posedge clk); #2;
    push(4'd3, rdy);
    mute = 1'b0;
    wait_q(11);
    check("unmute_x",     ent(10).x, 3);
    check("unmute_state", ent(10).st, 1);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 299) == 0) begin
        rst_b = 1'b0;
        @(posedge clk); #2;
        rst_b = 1'b1;
      end
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 19) == 0) mute = ~mute;
      if ($urandom_range(0, 29) == 0) div = 8'($urandom_range(0, 6));
      sif.s_valid = 1'($urandom_range(0, 1));
      sif.s_data  = 4'($urandom_range(0, 15));
    end

    @(posedge clk); #3;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
